uart_rx_param: RTL
==================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter PARITY_MODE, default 1, 0=none, 1=even, 2=odd.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal 1..2).
REQ-004 SHALL have parameter OVERSAMPLE, default 16, sample_tick pulses per bit (even, 8..32).
REQ-005 SHALL have port clk  input  1  system clock, single clock domain.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port sample_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate.
REQ-008 SHALL have port rxd  input  1  asynchronous serial input, idle high.
REQ-009 SHALL have port data_out  output  DATA_BITS  received word, LSB first on line.
REQ-010 SHALL have port rx_valid  output  1  data_out and its flags are valid.
REQ-011 SHALL have port rx_accept  input  1  consumer takes data_out when rx_valid=1.
REQ-012 SHALL have port parity_error  output  1  parity mismatch on held word.
REQ-013 SHALL have port framing_error  output  1  stop bit sampled low on held word.
REQ-014 SHALL have port overrun_error  output  1  one-clk pulse, completed frame dropped.
REQ-015 SHALL have port break_detect  output  1  one-clk pulse on line break.

Function
REQ-016 SHALL pass rxd through a 2-flop synchroniser; all decisions use the synchronised value.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE; only sample_tick cycles advance the tick counter.
REQ-018 IDLE->START SHALL occur on a sample_tick with synchronised rxd low.
REQ-019 START SHALL sample after OVERSAMPLE/2 ticks; low -> DATA, high -> IDLE (glitch rejected, no outputs change).
REQ-020 DATA, PARITY, STOP SHALL each sample once every OVERSAMPLE ticks at bit centre; DATA collects DATA_BITS bits LSB first.
REQ-021 PARITY state SHALL be skipped when PARITY_MODE=0; parity_error then always 0.
REQ-022 Parity check: even -> XOR(data, parity bit)=0 required; odd -> =1 required.
REQ-023 STOP SHALL sample STOP_BITS bits; any low stop sample sets the frame's framing error.
REQ-024 Frame completion SHALL be the clk cycle after the final stop-bit sample; state returns to IDLE (WAIT_IDLE if last stop sample low, until rxd high).
REQ-025 At completion with rx_valid=0, or rx_valid=1 and rx_accept=1 same cycle: load data_out, parity_error, framing_error; rx_valid=1 next cycle.
REQ-026 At completion with rx_valid=1 and rx_accept=0: new frame discarded, held word unchanged, overrun_error pulses one clk.
REQ-027 rx_accept with rx_valid=1 and no completion SHALL clear rx_valid next cycle; rx_accept with rx_valid=0 is ignored.
REQ-028 Frames with parity/framing error SHALL still be delivered with flags set; flags hold until next load.
REQ-029 Receiver SHALL accept a new start bit in the tick immediately after completion (back-to-back frames).

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, counters 0, synchroniser flops 1, data_out 0, rx_valid 0, all error and break outputs 0.
REQ-031 Reset mid-frame SHALL discard the partial frame; first frame after release SHALL be received correctly.

Configuration
REQ-032 Macro UART_RX_BREAK_DETECT_EN defined: frame with all data, parity and stop samples low SHALL pulse break_detect one clk, not load data or set rx_valid, then enter WAIT_IDLE.
REQ-033 Macro undefined: break_detect SHALL be tied 0 and a break SHALL be delivered as data 0 with framing_error=1.

Verification
REQ-034 8E1, OVERSAMPLE=16, send 0xA5 correct parity -> data_out=0xA5, rx_valid=1, both error flags 0; rx_accept -> rx_valid 0 next clk.
REQ-035 8E1, send 0x3C with parity bit 1 -> data_out=0x3C, parity_error=1, framing_error=0.
REQ-036 DATA_BITS=7, PARITY_MODE=2, STOP_BITS=2, send 0x55, second stop low -> data_out=0x55, framing_error=1.
REQ-037 rxd low for 6 ticks then high -> no rx_valid, state back to IDLE; next 0x12 received correctly.
REQ-038 Two frames 0x11, 0x22 with rx_accept held 0 -> data_out=0x11, overrun_error one-clk pulse at second completion.
REQ-039 Macro defined, rxd low for 12 bit times -> break_detect one pulse, rx_valid stays 0; after rxd high, 0x81 received correctly.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// -----------------------------------------------------------------------------
// uart_rx_param_if
//
// Purpose: bundles the receiver's word-delivery side (received word, valid /
// accept handshake and the per-word status flags) so the receiver and its
// consumer connect through one port.
//
// Parameters:
//   DATA_BITS     width of the received word, must match the receiver
//
// Signals:
//   data_out      received word (first bit on the line is bit 0)
//   rx_valid      data_out and its flags hold a word not yet taken
//   rx_accept     consumer takes the held word while rx_valid is high
//   parity_error  parity mismatch on the held word
//   framing_error a stop bit was sampled low on the held word
//   overrun_error one-clk pulse, a completed frame was dropped
//   break_detect  one-clk pulse when a line break is recognised
//
// Modports:
//   master        the receiver (drives the word and flags, reads rx_accept)
//   slave         the consumer (reads the word and flags, drives rx_accept)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] data_out;
  logic                 rx_valid;
  logic                 rx_accept;
  logic                 parity_error;
  logic                 framing_error;
  logic                 overrun_error;
  logic                 break_detect;

  modport master (
    output data_out,
    output rx_valid,
    output parity_error,
    output framing_error,
    output overrun_error,
    output break_detect,
    input  rx_accept
  );

  modport slave (
    input  data_out,
    input  rx_valid,
    input  parity_error,
    input  framing_error,
    input  overrun_error,
    input  break_detect,
    output rx_accept
  );

endinterface

// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
//
// Purpose: parameterised oversampling UART receiver. The serial line is
// synchronised, a start bit is qualified at its centre, data / parity / stop
// bits are sampled once per bit at their centres, and each completed frame is
// offered to the consumer through a single-entry valid/accept holding register.
//
// Parameters:
//   DATA_BITS    data bits per frame (5..9)
//   PARITY_MODE  0 = none, 1 = even, 2 = odd
//   STOP_BITS    stop bits per frame (1..2)
//   OVERSAMPLE   sample_tick pulses per bit time (even, 8..32)
//
// Ports:
//   clk          system clock, single clock domain
//   rst_n        asynchronous active-low reset
//   sample_tick  one-clk pulse at OVERSAMPLE x baud rate
//   rxd          asynchronous serial input, idle high
//   rx_if        word-delivery interface (master side), see uart_rx_param_if
//
// Configuration macro:
//   UART_RX_BREAK_DETECT_EN  when defined, a frame whose data, parity and stop
//                            samples are all low is reported as a one-clk
//                            break_detect pulse instead of being delivered.
//                            When undefined, break_detect stays 0 and a break
//                            arrives as data 0 with framing_error set.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sample_tick,
  input  logic            rxd,
  uart_rx_param_if.master rx_if
);

  // Counter widths: the tick counter reaches OVERSAMPLE-1, the bit counter
  // reaches DATA_BITS-1 (stop bits need fewer).
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  // Required XOR of data and parity bit: 0 for even, 1 for odd.
  localparam logic PARITY_ODD = (PARITY_MODE == 2);

`ifdef UART_RX_BREAK_DETECT_EN
  localparam logic BREAK_EN = 1'b1;
`else
  localparam logic BREAK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  // Synchroniser and frame-assembly state.
  logic                 rx_meta;
  logic                 rx_sync;
  state_t               state,      state_next;
  logic [TICK_W-1:0]    tick_cnt,   tick_cnt_next;
  logic [BIT_W-1:0]     bit_cnt,    bit_cnt_next;
  logic [DATA_BITS-1:0] data_sr,    data_sr_next;
  logic                 parity_acc, parity_acc_next;
  logic                 par_err,    par_err_next;
  logic                 frm_err,    frm_err_next;
  logic                 all_low,    all_low_next;
  logic                 done,       done_next;

  // Holding register presented to the consumer.
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 ovr_q;
  logic                 brk_q;

  logic                 is_break;

  // Two-flop synchroniser on the raw line. Both flops reset to the idle level
  // so leaving reset never looks like a falling edge on the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
    end
  end

  // Frame state register. Everything that describes the frame in flight is
  // registered here together so a reset throws away a partial frame cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      data_sr    <= '0;
      parity_acc <= 1'b0;
      par_err    <= 1'b0;
      frm_err    <= 1'b0;
      all_low    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      tick_cnt   <= tick_cnt_next;
      bit_cnt    <= bit_cnt_next;
      data_sr    <= data_sr_next;
      parity_acc <= parity_acc_next;
      par_err    <= par_err_next;
      frm_err    <= frm_err_next;
      all_low    <= all_low_next;
      done       <= done_next;
    end
  end

  // Next-state and frame datapath. Nothing moves except on sample_tick cycles.
  // START waits half a bit so every later sample lands a whole bit apart at
  // the bit centres. all_low tracks whether every data, parity and stop sample
  // was low, which is what distinguishes a break from an ordinary bad frame.
  // done is raised for exactly one clk, the cycle after the last stop sample;
  // by then par_err and frm_err already include that final sample.
  always_comb begin
    state_next      = state;
    tick_cnt_next   = tick_cnt;
    bit_cnt_next    = bit_cnt;
    data_sr_next    = data_sr;
    parity_acc_next = parity_acc;
    par_err_next    = par_err;
    frm_err_next    = frm_err;
    all_low_next    = all_low;
    done_next       = 1'b0;

    case (state)
      IDLE: begin
        if (sample_tick && !rx_sync) begin
          state_next    = START;
          tick_cnt_next = '0;
        end
      end

      START: begin
        if (sample_tick) begin
          if (tick_cnt == HALF_LAST) begin
            tick_cnt_next = '0;
            if (!rx_sync) begin
              state_next      = DATA;
              bit_cnt_next    = '0;
              parity_acc_next = 1'b0;
              par_err_next    = 1'b0;
              frm_err_next    = 1'b0;
              all_low_next    = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            tick_cnt_next = tick_cnt + TICK_W'(1);
          end
        end
      end

      DATA: begin
        if (sample_tick) begin
          if (tick_cnt == FULL_LAST) begin
            tick_cnt_next   = '0;
            data_sr_next    = {rx_sync, data_sr[DATA_BITS-1:1]};
            parity_acc_next = parity_acc ^ rx_sync;
            if (rx_sync) begin
              all_low_next = 1'b0;
            end
            if (bit_cnt == DATA_LAST) begin
              bit_cnt_next = '0;
              state_next   = (PARITY_MODE != 0) ? PARITY : STOP;
            end else begin
              bit_cnt_next = bit_cnt + BIT_W'(1);
            end
          end else begin
            tick_cnt_next = tick_cnt + TICK_W'(1);
          end
        end
      end

      PARITY: begin
        if (sample_tick) begin
          if (tick_cnt == FULL_LAST) begin
            tick_cnt_next = '0;
            par_err_next  = ((parity_acc ^ rx_sync) != PARITY_ODD);
            if (rx_sync) begin
              all_low_next = 1'b0;
            end
            bit_cnt_next = '0;
            state_next   = STOP;
          end else begin
            tick_cnt_next = tick_cnt + TICK_W'(1);
          end
        end
      end

      STOP: begin
        if (sample_tick) begin
          if (tick_cnt == FULL_LAST) begin
            tick_cnt_next = '0;
            if (!rx_sync) begin
              frm_err_next = 1'b1;
            end else begin
              all_low_next = 1'b0;
            end
            if (bit_cnt == STOP_LAST) begin
              bit_cnt_next = '0;
              done_next    = 1'b1;
              state_next   = rx_sync ? IDLE : WAIT_IDLE;
            end else begin
              bit_cnt_next = bit_cnt + BIT_W'(1);
            end
          end else begin
            tick_cnt_next = tick_cnt + TICK_W'(1);
          end
        end
      end

      WAIT_IDLE: begin
        if (sample_tick && rx_sync) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign is_break = BREAK_EN && all_low;

  // Single-entry holding register. A completed frame loads only if the slot is
  // empty or is being emptied in the same cycle; otherwise the new frame is
  // dropped and overrun pulses. A recognised break never loads the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      brk_q <= 1'b0;
      if (valid_q && rx_if.rx_accept) begin
        valid_q <= 1'b0;
      end
      if (done) begin
        if (is_break) begin
          brk_q <= 1'b1;
        end else if (!valid_q || rx_if.rx_accept) begin
          data_q  <= data_sr;
          perr_q  <= par_err;
          ferr_q  <= frm_err;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end
    end
  end

  assign rx_if.data_out      = data_q;
  assign rx_if.rx_valid      = valid_q;
  assign rx_if.parity_error  = perr_q;
  assign rx_if.framing_error = ferr_q;
  assign rx_if.overrun_error = ovr_q;
  assign rx_if.break_detect  = brk_q;

endmodule
